// File: rtl/cook_seq_pkg.sv
// Shared state encoding, table geometry and power levels for the cook sequencer.
package cook_seq_pkg;
   localparam int MAX_STAGES = 4;
   localparam int TIME_W     = 7;
   localparam int IDX_W      = 2;
   localparam int CNT_W      = 3;

   localparam logic HALF = 1'b0;
   localparam logic FULL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/stage_table.sv
// Four-entry {power, time} stage register file, append-only through a write pointer.
// Clear drops the entry count and wins over a same-cycle write.
module stage_table
   import cook_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic              wr_power,
   input  logic [TIME_W-1:0] wr_time,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_power,
   output logic [TIME_W-1:0] rd_time,
   output logic [CNT_W-1:0]  count
);
   logic              pw_q [MAX_STAGES];
   logic [TIME_W-1:0] tm_q [MAX_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         for (int i = 0; i < MAX_STAGES; i++) begin
            pw_q[i] <= HALF;
            tm_q[i] <= '0;
         end
      end else if (clear) begin
         count <= '0;
      end else if (wr_en && (count < CNT_W'(MAX_STAGES))) begin
         pw_q[count[IDX_W-1:0]] <= wr_power;
         tm_q[count[IDX_W-1:0]] <= wr_time;
         count                  <= count + CNT_W'(1);
      end
   end

   assign rd_power = pw_q[rd_idx];
   assign rd_time  = tm_q[rd_idx];
endmodule

// File: rtl/cook_program_sequencer.sv
// Multi-stage microwave cook sequencer: up to four {power, time} stages run back to back,
// one clock per second, with door pause, cancel and a one-cycle completion strobe.
module cook_program_sequencer
   import cook_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_valid,
   input  logic              prog_power,
   input  logic [TIME_W-1:0] prog_time,
   output logic              prog_ready,
   input  logic              start_button,
   input  logic              cancel_button,
   input  logic              door_status,
   output logic              power,
   output logic [TIME_W-1:0] timer,
   output logic              heating,
   output logic [IDX_W-1:0]  stage_idx,
   output logic [CNT_W-1:0]  stages_loaded,
   output logic [1:0]        state_code,
   output logic              done_pulse
);
   state_t            state;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_power;
   logic [TIME_W-1:0] rd_time;
   logic              table_clear;
   logic              table_wr;
   logic              last_stage;

   assign prog_ready  = (state == ST_IDLE) && (stages_loaded < CNT_W'(MAX_STAGES));
   assign state_code  = state;
   assign table_clear = cancel_button || ((state == ST_DONE) && !door_status);
   assign table_wr    = prog_valid && prog_ready && (prog_time != '0);
   // IDLE reads entry 0 for the start; COOK looks one entry ahead for a seamless advance.
   assign rd_idx      = (state == ST_IDLE) ? '0 : stage_idx + IDX_W'(1);
   assign last_stage  = (({1'b0, stage_idx} + CNT_W'(1)) == stages_loaded);

   stage_table u_table (
      .clk      (clk),
      .rst      (rst),
      .clear    (table_clear),
      .wr_en    (table_wr),
      .wr_power (prog_power),
      .wr_time  (prog_time),
      .rd_idx   (rd_idx),
      .rd_power (rd_power),
      .rd_time  (rd_time),
      .count    (stages_loaded)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         power      <= HALF;
         heating    <= 1'b0;
         stage_idx  <= '0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (table_clear) begin
            state     <= ST_IDLE;
            timer     <= '0;
            power     <= HALF;
            heating   <= 1'b0;
            stage_idx <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_button && door_status && (stages_loaded != '0)) begin
                     state     <= ST_COOK;
                     stage_idx <= '0;
                     timer     <= rd_time;
                     power     <= rd_power;
                     heating   <= 1'b1;
                  end
               end
               ST_COOK: begin
                  if (!door_status) begin
                     state   <= ST_PAUSE;
                     heating <= 1'b0;
                  end else if (timer == TIME_W'(1)) begin
                     if (last_stage) begin
                        state      <= ST_DONE;
                        timer      <= '0;
                        heating    <= 1'b0;
                        done_pulse <= 1'b1;
                     end else begin
                        stage_idx <= stage_idx + IDX_W'(1);
                        timer     <= rd_time;
                        power     <= rd_power;
                     end
                  end else begin
                     timer <= timer - TIME_W'(1);
                  end
               end
               ST_PAUSE: begin
                  if (start_button && door_status) begin
                     state   <= ST_COOK;
                     heating <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cook_program_sequencer.sv
// Bench for cook_program_sequencer: directed scenarios plus randomized traffic against a stage-list model.
module tb_cook_program_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       prog_valid = 1'b0;
   logic       prog_power = 1'b0;
   logic [6:0] prog_time = '0;
   logic       start_button = 1'b0;
   logic       cancel_button = 1'b0;
   logic       door_status = 1'b1;
   logic       prog_ready, power, heating, done_pulse;
   logic [6:0] timer;
   logic [1:0] stage_idx, state_code;
   logic [2:0] stages_loaded;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Model: the programmed stage list plus where the cook currently stands in it.
   int m_mode = 0;
   int m_n = 0;
   int m_idx = 0;
   int m_left = 0;
   int m_pow = 0;
   bit m_done = 1'b0;
   int m_tm [4];
   int m_pw [4];

   int seq_t [5] = '{3, 2, 1, 2, 1};
   int seq_p [5] = '{1, 1, 1, 0, 0};

   cook_program_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .prog_valid    (prog_valid),
      .prog_power    (prog_power),
      .prog_time     (prog_time),
      .prog_ready    (prog_ready),
      .start_button  (start_button),
      .cancel_button (cancel_button),
      .door_status   (door_status),
      .power         (power),
      .timer         (timer),
      .heating       (heating),
      .stage_idx     (stage_idx),
      .stages_loaded (stages_loaded),
      .state_code    (state_code),
      .done_pulse    (done_pulse)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_idle();
      m_mode = 0;
      m_left = 0;
      m_pow  = 0;
      m_idx  = 0;
   endtask

   task automatic model_reset();
      model_idle();
      m_n    = 0;
      m_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_tm[i] = 0;
         m_pw[i] = 0;
      end
   endtask

   task automatic model_step();
      bit go;
      m_done = 1'b0;
      if (cancel_button) begin
         m_n = 0;
         model_idle();
      end else if (m_mode == 0) begin
         go = start_button && door_status && (m_n > 0);
         if (prog_valid && (m_n < 4) && (prog_time != 0)) begin
            m_tm[m_n] = int'(prog_time);
            m_pw[m_n] = int'(prog_power);
            m_n++;
         end
         if (go) begin
            m_mode = 1;
            m_idx  = 0;
            m_left = m_tm[0];
            m_pow  = m_pw[0];
         end
      end else if (m_mode == 1) begin
         if (!door_status) m_mode = 2;
         else if (m_left > 1) m_left--;
         else if (m_idx == m_n - 1) begin
            m_mode = 3;
            m_left = 0;
            m_done = 1'b1;
         end else begin
            m_idx++;
            m_left = m_tm[m_idx];
            m_pow  = m_pw[m_idx];
         end
      end else if (m_mode == 2) begin
         if (start_button && door_status) m_mode = 1;
      end else begin
         if (!door_status) begin
            m_n = 0;
            model_idle();
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("state_code", int'(state_code), m_mode);
         cmp("timer", int'(timer), m_left);
         cmp("power", int'(power), m_pow);
         cmp("heating", int'(heating), int'(m_mode == 1));
         cmp("stage_idx", int'(stage_idx), m_idx);
         cmp("stages_loaded", int'(stages_loaded), m_n);
         cmp("done_pulse", int'(done_pulse), int'(m_done));
         cmp("prog_ready", int'(prog_ready), int'((m_mode == 0) && (m_n < 4)));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic p, input int t);
      prog_valid = 1'b1;
      prog_power = p;
      prog_time  = 7'(t);
      tick();
      prog_valid = 1'b0;
   endtask

   task automatic press_start();
      start_button = 1'b1;
      tick();
      start_button = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      tick();
      cmp("rst_state", int'(state_code), 0);
      cmp("rst_timer", int'(timer), 0);
      cmp("rst_heating", int'(heating), 0);
      cmp("rst_loaded", int'(stages_loaded), 0);
      cmp("rst_ready", int'(prog_ready), 1);

      // Two stages back to back.
      load(1'b1, 3);
      load(1'b0, 2);
      cmp("two_loaded", int'(stages_loaded), 2);
      press_start();
      cmp("model_first_timer", m_left, 3);
      for (int i = 0; i < 5; i++) begin
         cmp("seq_timer", int'(timer), seq_t[i]);
         cmp("seq_power", int'(power), seq_p[i]);
         cmp("seq_heating", int'(heating), 1);
         tick();
      end
      cmp("seq_done_pulse", int'(done_pulse), 1);
      cmp("seq_done_state", int'(state_code), 3);
      cmp("seq_done_heating", int'(heating), 0);
      cmp("seq_done_timer", int'(timer), 0);
      cmp("model_done", int'(m_done), 1);
      tick();
      cmp("seq_pulse_one_cycle", int'(done_pulse), 0);
      cmp("seq_stay_done", int'(state_code), 3);
      door_status = 1'b0;
      tick();
      door_status = 1'b1;
      cmp("done_exit_state", int'(state_code), 0);
      cmp("done_exit_loaded", int'(stages_loaded), 0);

      // Door opened with two seconds left.
      load(1'b1, 3);
      press_start();
      cmp("pause_pre_timer3", int'(timer), 3);
      tick();
      cmp("pause_pre_timer2", int'(timer), 2);
      door_status = 1'b0;
      tick();
      cmp("pause_state", int'(state_code), 2);
      cmp("pause_timer", int'(timer), 2);
      cmp("pause_heating", int'(heating), 0);
      cmp("model_pause_left", m_left, 2);
      tick();
      cmp("pause_hold_timer", int'(timer), 2);
      door_status = 1'b1;
      press_start();
      cmp("resume_state", int'(state_code), 1);
      cmp("resume_timer", int'(timer), 2);
      cmp("resume_heating", int'(heating), 1);
      tick();
      cmp("resume_timer1", int'(timer), 1);
      tick();
      cmp("resume_done", int'(state_code), 3);
      cmp("resume_done_pulse", int'(done_pulse), 1);
      door_status = 1'b0;
      tick();
      door_status = 1'b1;

      // Cancel while cooking.
      load(1'b0, 5);
      press_start();
      tick();
      cmp("cancel_pre_timer", int'(timer), 4);
      cancel_button = 1'b1;
      tick();
      cancel_button = 1'b0;
      cmp("cancel_state", int'(state_code), 0);
      cmp("cancel_loaded", int'(stages_loaded), 0);
      cmp("cancel_timer", int'(timer), 0);
      cmp("cancel_heating", int'(heating), 0);

      // Overfill and zero-time loads.
      load(1'b1, 0);
      cmp("zero_load_ignored", int'(stages_loaded), 0);
      for (int i = 1; i <= 5; i++) begin
         load(1'(i % 2), i);
         if (i == 4) begin
            cmp("full_loaded", int'(stages_loaded), 4);
            cmp("full_ready", int'(prog_ready), 0);
         end
      end
      cmp("overfill_loaded", int'(stages_loaded), 4);
      press_start();
      cmp("overfill_t0", int'(timer), 1);
      cmp("overfill_p0", int'(power), 1);
      tick();
      cmp("overfill_t1", int'(timer), 2);
      cmp("overfill_p1", int'(power), 0);
      cmp("overfill_idx1", int'(stage_idx), 1);
      cancel_button = 1'b1;
      tick();
      cancel_button = 1'b0;

      // Start refused: empty table, then door open.
      press_start();
      cmp("empty_start_state", int'(state_code), 0);
      cmp("empty_start_heating", int'(heating), 0);
      load(1'b1, 4);
      door_status = 1'b0;
      press_start();
      cmp("open_start_state", int'(state_code), 0);
      cmp("open_start_heating", int'(heating), 0);
      door_status = 1'b1;

      // Reset between edges mid-cook.
      press_start();
      cmp("rstmid_cook", int'(state_code), 1);
      tick();
      cmp("rstmid_timer", int'(timer), 3);
      #2 rst = 1'b1;
      #1;
      cmp("rstmid_heating", int'(heating), 0);
      cmp("rstmid_state", int'(state_code), 0);
      cmp("rstmid_timer0", int'(timer), 0);
      cmp("rstmid_power", int'(power), 0);
      cmp("rstmid_idx", int'(stage_idx), 0);
      cmp("rstmid_loaded", int'(stages_loaded), 0);
      cmp("rstmid_pulse", int'(done_pulse), 0);
      tick();
      rst = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         prog_valid    = ($urandom_range(0, 3) == 0);
         prog_power    = 1'($urandom_range(0, 1));
         prog_time     = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
         if ($urandom_range(0, 49) == 0) prog_time = 7'd127;
         start_button  = ($urandom_range(0, 7) == 0);
         cancel_button = ($urandom_range(0, 99) == 0);
         door_status   = ($urandom_range(0, 19) != 0);
         tick();
      end
      prog_valid    = 1'b0;
      start_button  = 1'b0;
      cancel_button = 1'b0;
      door_status   = 1'b1;
      tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cook_program_sequencer.md
COOK_PROGRAM_SEQUENCER -- requirements
Module: cook_program_sequencer

Interface
REQ-001 SHALL: clk  in  1  single clock; one cycle = one second of cook time.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: prog_valid  in  1  stage-load request.
REQ-004 SHALL: prog_power  in  1  stage power level: 0 = HALF, 1 = FULL.
REQ-005 SHALL: prog_time  in  7  stage duration in seconds, legal range 1..127.
REQ-006 SHALL: prog_ready  out  1  stage table accepts a load this cycle.
REQ-007 SHALL: start_button  in  1  start/resume request, level-sampled each cycle.
REQ-008 SHALL: cancel_button  in  1  abort request.
REQ-009 SHALL: door_status  in  1  1 = closed, 0 = open.
REQ-010 SHALL: power  out  1  power of the active stage.
REQ-011 SHALL: timer  out  7  seconds remaining in the active stage.
REQ-012 SHALL: heating  out  1  magnetron enable.
REQ-013 SHALL: stage_idx  out  2  active stage number.
REQ-014 SHALL: stages_loaded  out  3  entries in the table, 0..4.
REQ-015 SHALL: state_code  out  2  encoding IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-016 SHALL: done_pulse  out  1  one-cycle completion strobe.

Function
REQ-017 SHALL: state machine with states IDLE, COOK, PAUSE, DONE.
REQ-018 SHALL: prog_ready = 1 only in IDLE with stages_loaded < 4.
REQ-019 SHALL: a load occurs when prog_valid, prog_ready and prog_time != 0; the entry is written at index stages_loaded, and stages_loaded increments.
REQ-020 SHALL: a prog_valid with prog_time = 0, or with prog_ready = 0, is ignored with no state change.
REQ-021 SHALL: IDLE -> COOK on start_button & door_status & stages_loaded > 0, with these register updates at that edge:
  - stage_idx = 0;
  - timer = time of entry 0;
  - power = power of entry 0.
REQ-022 SHALL: start_button is ignored in IDLE when the door is open or the table is empty.
REQ-023 SHALL: in COOK, heating = 1 and timer decrements by 1 per cycle; each stage therefore heats for exactly its programmed number of cycles.
REQ-024 SHALL: in COOK with timer = 1 and stage_idx < stages_loaded-1, the next edge advances to the next stage:
  - stage_idx increments;
  - timer and power load from the next entry;
  - no idle gap between stages.
REQ-025 SHALL: in COOK with timer = 1 on the last stage, the next edge enters DONE with timer = 0 and done_pulse = 1 for exactly that one cycle.
REQ-026 SHALL: in COOK, door_status = 0 goes to PAUSE; timer and stage_idx hold (no decrement that cycle), and heating = 0.
REQ-027 SHALL: PAUSE -> COOK on start_button & door_status; cook resumes from the held timer value.
REQ-028 SHALL: DONE -> IDLE when door_status = 0; the table is cleared (stages_loaded = 0).
REQ-029 SHALL: cancel_button in COOK, PAUSE or DONE goes to IDLE next cycle, clearing the table, with timer = 0 and heating = 0.
REQ-030 SHALL: cancel_button in IDLE clears the table; it overrides a simultaneous load.
REQ-031 SHALL: priority per cycle is cancel > door open > start > timer decrement/stage advance.
REQ-032 SHALL: all outputs are registered; heating is 0 in every state except COOK.

Reset
REQ-033 SHALL: on rst = 1, asynchronously and regardless of state:
  - state = IDLE;
  - timer = 0, power = 0, heating = 0, stage_idx = 0;
  - stages_loaded = 0, done_pulse = 0;
  - table contents invalidated.
REQ-034 SHALL: rst asserted mid-COOK drops heating in the same cycle, without waiting for a clock edge.

Structure
REQ-035 SHALL: package cook_seq_pkg holds:
  - the state enum;
  - MAX_STAGES = 4;
  - TIME_W = 7;
  - power level constants HALF = 0, FULL = 1.
REQ-036 SHALL: the 4-entry {power, time} register file with write pointer and clear is sub-module stage_table; all sequencing stays in the top module.

Verification
REQ-037 SHALL: load (FULL,3) then (HALF,2), close the door and pulse start -> required response:
  - timer reads 3,2,1 with power = 1, then 2,1 with power = 0;
  - heating = 1 for exactly 5 cycles;
  - done_pulse on the next cycle, state DONE.
REQ-038 SHALL: open the door when timer = 2 -> required response:
  - PAUSE with timer holding 2 and heating = 0;
  - after the door closes and start is pulsed, timer resumes 2,1 then DONE.
REQ-039 SHALL: cancel mid-COOK -> IDLE next cycle with stages_loaded = 0, timer = 0, heating = 0.
REQ-040 SHALL: attempt 5 loads plus 1 load with prog_time = 0 -> stages_loaded = 4, prog_ready = 0 after the fourth load, and the extra loads are ignored.
REQ-041 SHALL: start with the door open, and start with an empty table -> state stays IDLE with heating = 0.
REQ-042 SHALL: assert rst mid-COOK between clock edges -> all outputs reach reset values immediately.
